// File: rtl/vga_pkg.sv
// Shared VGA timing definitions.
//
// Provides the per-axis timing struct, the 640x480@60 segment defaults and the
// small helper functions used to derive totals and to check configurations at
// elaboration time.
package vga_pkg;

  // Segment lengths for one axis, in pixels (horizontal) or lines (vertical).
  typedef struct packed {
    int unsigned active;
    int unsigned front;
    int unsigned sync;
    int unsigned back;
  } vga_axis_timing_t;

  // 640x480@60 defaults.
  localparam vga_axis_timing_t VgaH640 = '{active: 640, front: 16, sync: 96, back: 48};
  localparam vga_axis_timing_t VgaV480 = '{active: 480, front: 10, sync: 2,  back: 33};

  // Both syncs are active-low in the 640x480@60 mode.
  localparam logic VgaSyncPolDefault = 1'b0;

  // Full period of one axis.
  function automatic int unsigned axis_total(vga_axis_timing_t t);
    return t.active + t.front + t.sync + t.back;
  endfunction

  // Every segment must be at least one unit long.
  function automatic bit axis_valid(vga_axis_timing_t t);
    return (t.active >= 1) && (t.front >= 1) && (t.sync >= 1) && (t.back >= 1);
  endfunction

  // True when value is representable in an unsigned field of the given width.
  function automatic bit fits_bits(int unsigned value, int unsigned bits);
    if (bits >= 32) begin
      return 1'b1;
    end
    return (value >> bits) == 0;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrapping position counter for one VGA axis.
//
// Counts 0..TOTAL-1, stepping once per clock where advance_in is high and
// wrapping to 0 after TOTAL-1. wrap_out flags the edge on which the wrap will
// happen, so it can step the next axis in the same cycle.
//
// Ports:
//   clock_in    rising-edge clock
//   reset_n_in  asynchronous active-low reset, clears the count
//   advance_in  step request for this clock
//   count_out   current count (registered)
//   wrap_out    high when this edge takes the count from TOTAL-1 back to 0
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned WIDTH_BITS = 10,
  parameter int unsigned TOTAL      = 800
) (
  input  logic                  clock_in,
  input  logic                  reset_n_in,
  input  logic                  advance_in,
  output logic [WIDTH_BITS-1:0] count_out,
  output logic                  wrap_out
);

  if ((TOTAL < 1) || !fits_bits(TOTAL - 1, WIDTH_BITS)) begin : gen_bad_total
    $error("vga_axis_counter: TOTAL-1 does not fit in WIDTH_BITS");
  end

  localparam logic [WIDTH_BITS-1:0] LastCount = WIDTH_BITS'(TOTAL - 1);

  logic [WIDTH_BITS-1:0] count_q, count_d;

  assign wrap_out = advance_in && (count_q == LastCount);

  always_comb begin
    count_d = count_q;
    if (wrap_out) begin
      count_d = '0;
    end else if (advance_in) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_out = count_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator.
//
// Walks a (h,v) position across the full raster, one pixel per clock where
// pixel_enable_in is high, and produces sync, blanking and start-of-line /
// start-of-frame strobes for that position.
//
// Every output is a flop. The decoded outputs are registered from the position
// the counters are about to take, so they always line up with pixel_x_out /
// pixel_y_out in the same cycle.
//
// Ports:
//   clock_in         rising-edge clock
//   reset_n_in       asynchronous active-low reset
//   pixel_enable_in  advance one pixel on this edge
//   h_sync_out       horizontal sync, asserted level H_SYNC_POL
//   v_sync_out       vertical sync, asserted level V_SYNC_POL
//   display_on_out   position lies in the active area
//   pixel_x_out      horizontal count
//   pixel_y_out      vertical count
//   line_start_out   one-clock strobe on entry to h=0
//   frame_start_out  one-clock strobe on entry to (0,0)
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned WIDTH_BITS  = 10,
  parameter int unsigned HEIGHT_BITS = 10,
  parameter int unsigned H_ACTIVE    = VgaH640.active,
  parameter int unsigned H_FRONT     = VgaH640.front,
  parameter int unsigned H_SYNC      = VgaH640.sync,
  parameter int unsigned H_BACK      = VgaH640.back,
  parameter int unsigned V_ACTIVE    = VgaV480.active,
  parameter int unsigned V_FRONT     = VgaV480.front,
  parameter int unsigned V_SYNC      = VgaV480.sync,
  parameter int unsigned V_BACK      = VgaV480.back,
  parameter logic        H_SYNC_POL  = VgaSyncPolDefault,
  parameter logic        V_SYNC_POL  = VgaSyncPolDefault
) (
  input  logic                   clock_in,
  input  logic                   reset_n_in,
  input  logic                   pixel_enable_in,
  output logic                   h_sync_out,
  output logic                   v_sync_out,
  output logic                   display_on_out,
  output logic [WIDTH_BITS-1:0]  pixel_x_out,
  output logic [HEIGHT_BITS-1:0] pixel_y_out,
  output logic                   line_start_out,
  output logic                   frame_start_out
);

  localparam vga_axis_timing_t HTiming = '{
    active: H_ACTIVE, front: H_FRONT, sync: H_SYNC, back: H_BACK
  };
  localparam vga_axis_timing_t VTiming = '{
    active: V_ACTIVE, front: V_FRONT, sync: V_SYNC, back: V_BACK
  };

  localparam int unsigned H_TOTAL = axis_total(HTiming);
  localparam int unsigned V_TOTAL = axis_total(VTiming);

  if (!axis_valid(HTiming) || !axis_valid(VTiming)) begin : gen_bad_segment
    $error("vga_timing_gen: every timing segment must be at least 1 long");
  end

  if (!fits_bits(H_TOTAL - 1, WIDTH_BITS)) begin : gen_bad_width
    $error("vga_timing_gen: H_TOTAL-1 does not fit in WIDTH_BITS");
  end

  if (!fits_bits(V_TOTAL - 1, HEIGHT_BITS)) begin : gen_bad_height
    $error("vga_timing_gen: V_TOTAL-1 does not fit in HEIGHT_BITS");
  end

  // Segment boundaries as counter-width constants. Each one is at most
  // TOTAL-1 because the back porch is non-empty, so none of them truncate.
  localparam logic [WIDTH_BITS-1:0]  HActiveEnd = WIDTH_BITS'(H_ACTIVE);
  localparam logic [WIDTH_BITS-1:0]  HSyncStart = WIDTH_BITS'(H_ACTIVE + H_FRONT);
  localparam logic [WIDTH_BITS-1:0]  HSyncEnd   = WIDTH_BITS'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [HEIGHT_BITS-1:0] VActiveEnd = HEIGHT_BITS'(V_ACTIVE);
  localparam logic [HEIGHT_BITS-1:0] VSyncStart = HEIGHT_BITS'(V_ACTIVE + V_FRONT);
  localparam logic [HEIGHT_BITS-1:0] VSyncEnd   = HEIGHT_BITS'(V_ACTIVE + V_FRONT + V_SYNC);

  // ---------------------------------------------------------------------------
  // Position counters: h steps on pixel enable, v steps on each h wrap.
  // ---------------------------------------------------------------------------
  logic [WIDTH_BITS-1:0]  h_count;
  logic [HEIGHT_BITS-1:0] v_count;
  logic                   h_wrap;
  logic                   v_wrap;

  vga_axis_counter #(
    .WIDTH_BITS (WIDTH_BITS),
    .TOTAL      (H_TOTAL)
  ) u_h_counter (
    .clock_in   (clock_in),
    .reset_n_in (reset_n_in),
    .advance_in (pixel_enable_in),
    .count_out  (h_count),
    .wrap_out   (h_wrap)
  );

  vga_axis_counter #(
    .WIDTH_BITS (HEIGHT_BITS),
    .TOTAL      (V_TOTAL)
  ) u_v_counter (
    .clock_in   (clock_in),
    .reset_n_in (reset_n_in),
    .advance_in (h_wrap),
    .count_out  (v_count),
    .wrap_out   (v_wrap)
  );

  // ---------------------------------------------------------------------------
  // Decode the position the counters will hold after this edge, so the
  // registered flags below change together with the counts.
  // ---------------------------------------------------------------------------
  logic [WIDTH_BITS-1:0]  h_next;
  logic [HEIGHT_BITS-1:0] v_next;
  logic                   display_d;
  logic                   h_sync_d;
  logic                   v_sync_d;

  always_comb begin
    h_next = h_count;
    if (h_wrap) begin
      h_next = '0;
    end else if (pixel_enable_in) begin
      h_next = h_count + 1'b1;
    end

    v_next = v_count;
    if (v_wrap) begin
      v_next = '0;
    end else if (h_wrap) begin
      v_next = v_count + 1'b1;
    end

    display_d = (h_next < HActiveEnd) && (v_next < VActiveEnd);
    h_sync_d  = ((h_next >= HSyncStart) && (h_next < HSyncEnd)) ? H_SYNC_POL : ~H_SYNC_POL;
    v_sync_d  = ((v_next >= VSyncStart) && (v_next < VSyncEnd)) ? V_SYNC_POL : ~V_SYNC_POL;
  end

  // ---------------------------------------------------------------------------
  // Output registers.
  // ---------------------------------------------------------------------------
  logic display_q;
  logic h_sync_q;
  logic v_sync_q;
  logic line_start_q;
  logic frame_start_q;

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      display_q     <= 1'b0;
      h_sync_q      <= ~H_SYNC_POL;
      v_sync_q      <= ~V_SYNC_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      display_q     <= display_d;
      h_sync_q      <= h_sync_d;
      v_sync_q      <= v_sync_d;
      // A wrap only happens on an enabled edge, so a held position never
      // re-fires the strobes. v only wraps on an h wrap, so the frame strobe
      // always coincides with a line strobe.
      line_start_q  <= h_wrap;
      frame_start_q <= v_wrap;
    end
  end

  assign h_sync_out      = h_sync_q;
  assign v_sync_out      = v_sync_q;
  assign display_on_out  = display_q;
  assign pixel_x_out     = h_count;
  assign pixel_y_out     = v_count;
  assign line_start_out  = line_start_q;
  assign frame_start_out = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. Four configurations share clock, reset and pixel
// enable: default 640x480 (d), a short-line/full-height one (t), an
// active-high sync one (p) and a minimal all-ones one (s). The reference model
// is a linear pixel index per configuration, h = idx % HT, v = idx / HT.
module tb_vga_timing_gen;

  localparam int DHT = 800;
  localparam int DVT = 525;
  localparam int THT = 5;
  localparam int TVT = 525;
  localparam int PHT = 5;
  localparam int PVT = 5;
  localparam int SHT = 4;
  localparam int SVT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic en = 1'b0;

  always #5 clk = ~clk;

  logic       d_hs, d_vs, d_de, d_ls, d_fs;
  logic [9:0] d_x, d_y;
  logic       t_hs, t_vs, t_de, t_ls, t_fs;
  logic [2:0] t_x;
  logic [9:0] t_y;
  logic       p_hs, p_vs, p_de, p_ls, p_fs;
  logic [2:0] p_x, p_y;
  logic       s_hs, s_vs, s_de, s_ls, s_fs;
  logic [2:0] s_x, s_y;

  vga_timing_gen dut_d (
    .clock_in(clk), .reset_n_in(rst_n), .pixel_enable_in(en),
    .h_sync_out(d_hs), .v_sync_out(d_vs), .display_on_out(d_de),
    .pixel_x_out(d_x), .pixel_y_out(d_y),
    .line_start_out(d_ls), .frame_start_out(d_fs)
  );

  vga_timing_gen #(
    .WIDTH_BITS(3), .HEIGHT_BITS(10),
    .H_ACTIVE(2), .H_FRONT(1), .H_SYNC(1), .H_BACK(1)
  ) dut_t (
    .clock_in(clk), .reset_n_in(rst_n), .pixel_enable_in(en),
    .h_sync_out(t_hs), .v_sync_out(t_vs), .display_on_out(t_de),
    .pixel_x_out(t_x), .pixel_y_out(t_y),
    .line_start_out(t_ls), .frame_start_out(t_fs)
  );

  vga_timing_gen #(
    .WIDTH_BITS(3), .HEIGHT_BITS(3),
    .H_ACTIVE(2), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_ACTIVE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
  ) dut_p (
    .clock_in(clk), .reset_n_in(rst_n), .pixel_enable_in(en),
    .h_sync_out(p_hs), .v_sync_out(p_vs), .display_on_out(p_de),
    .pixel_x_out(p_x), .pixel_y_out(p_y),
    .line_start_out(p_ls), .frame_start_out(p_fs)
  );

  vga_timing_gen #(
    .WIDTH_BITS(3), .HEIGHT_BITS(3),
    .H_ACTIVE(1), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_ACTIVE(1), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
  ) dut_s (
    .clock_in(clk), .reset_n_in(rst_n), .pixel_enable_in(en),
    .h_sync_out(s_hs), .v_sync_out(s_vs), .display_on_out(s_de),
    .pixel_x_out(s_x), .pixel_y_out(s_y),
    .line_start_out(s_ls), .frame_start_out(s_fs)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Reference model state: linear pixel index and the strobes expected now.
  int d_idx, t_idx, p_idx, s_idx;
  logic d_ls_e, d_fs_e, t_ls_e, t_fs_e, p_ls_e, p_fs_e, s_ls_e, s_fs_e;

  task automatic model_reset();
    d_idx = 0; t_idx = 0; p_idx = 0; s_idx = 0;
    d_ls_e = 0; d_fs_e = 0; t_ls_e = 0; t_fs_e = 0;
    p_ls_e = 0; p_fs_e = 0; s_ls_e = 0; s_fs_e = 0;
  endtask

  // Drive enable for one clock, then update the model to the new position.
  task automatic tick(input logic e);
    en = e;
    @(posedge clk);
    #1;
    cyc++;
    d_ls_e = e && (d_idx % DHT == DHT - 1);
    d_fs_e = e && (d_idx == DHT * DVT - 1);
    t_ls_e = e && (t_idx % THT == THT - 1);
    t_fs_e = e && (t_idx == THT * TVT - 1);
    p_ls_e = e && (p_idx % PHT == PHT - 1);
    p_fs_e = e && (p_idx == PHT * PVT - 1);
    s_ls_e = e && (s_idx % SHT == SHT - 1);
    s_fs_e = e && (s_idx == SHT * SVT - 1);
    if (e) begin
      d_idx = (d_idx + 1) % (DHT * DVT);
      t_idx = (t_idx + 1) % (THT * TVT);
      p_idx = (p_idx + 1) % (PHT * PVT);
      s_idx = (s_idx + 1) % (SHT * SVT);
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({d_x, d_y} !== 20'd0 || {d_de, d_ls, d_fs} !== 3'b000 || {d_hs, d_vs} !== 2'b11) begin
      n_bad++;
      $display("FAIL reset_async_d got x=%0d y=%0d de=%b ls=%b fs=%b hs=%b vs=%b want 0 0 0 0 0 1 1",
               d_x, d_y, d_de, d_ls, d_fs, d_hs, d_vs);
    end
    n_cmp++;
    if ({p_hs, p_vs} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_async_pol got hs=%b vs=%b want 0 0", p_hs, p_vs);
    end
    en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({d_x, d_y} !== 20'd0 || d_de !== 1'b0 || {p_hs, p_vs, s_de} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_held got x=%0d y=%0d de=%b p_hs=%b p_vs=%b s_de=%b want all 0",
               d_x, d_y, d_de, p_hs, p_vs, s_de);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_release();
    tick(1'b0);
    n_cmp++;
    if ({d_x, d_y} !== 20'd0 || d_de !== 1'b1 || {d_hs, d_vs} !== 2'b11 ||
        {d_ls, d_fs} !== 2'b00) begin
      n_bad++;
      $display("FAIL release_first got x=%0d y=%0d de=%b hs=%b vs=%b ls=%b fs=%b want 0 0 1 1 1 0 0",
               d_x, d_y, d_de, d_hs, d_vs, d_ls, d_fs);
    end
    tick(1'b1);
    n_cmp++;
    if (d_x !== 10'd1 || d_ls !== 1'b0 || d_de !== 1'b1) begin
      n_bad++;
      $display("FAIL release_step got x=%0d ls=%b de=%b want 1 0 1", d_x, d_ls, d_de);
    end
  endtask

  task automatic test_line_period();
    int h, v, last, lines;
    logic hs_e, de_e;
    last = -1;
    lines = 0;
    repeat (2500) begin
      tick(1'b1);
      h = d_idx % DHT;
      v = d_idx / DHT;
      hs_e = !(h >= 656 && h <= 751);
      de_e = (h < 640) && (v < 480);
      n_cmp++;
      if (d_x !== 10'(h) || d_y !== 10'(v) || d_hs !== hs_e || d_de !== de_e ||
          d_ls !== d_ls_e || d_fs !== d_fs_e) begin
        n_bad++;
        $display("FAIL line_period got x=%0d y=%0d hs=%b de=%b ls=%b fs=%b want %0d %0d %b %b %b %b",
                 d_x, d_y, d_hs, d_de, d_ls, d_fs, h, v, hs_e, de_e, d_ls_e, d_fs_e);
      end
      if (d_ls === 1'b1) begin
        lines++;
        if (last >= 0) begin
          n_cmp++;
          if (cyc - last != DHT) begin
            n_bad++;
            $display("FAIL line_interval got %0d want %0d", cyc - last, DHT);
          end
        end
        last = cyc;
      end
    end
    n_cmp++;
    if (lines != 3) begin
      n_bad++;
      $display("FAIL line_count got %0d want 3", lines);
    end
  endtask

  task automatic test_vsync_tall();
    int h, v, last, frames;
    logic vs_e, hs_e;
    last = -1;
    frames = 0;
    repeat (5400) begin
      tick(1'b1);
      h = t_idx % THT;
      v = t_idx / THT;
      vs_e = !(v >= 490 && v <= 491);
      hs_e = !(h == 3);
      n_cmp++;
      if (t_x !== 3'(h) || t_y !== 10'(v) || t_vs !== vs_e || t_hs !== hs_e ||
          t_ls !== t_ls_e || t_fs !== t_fs_e) begin
        n_bad++;
        $display("FAIL vsync_tall got x=%0d y=%0d vs=%b hs=%b ls=%b fs=%b want %0d %0d %b %b %b %b",
                 t_x, t_y, t_vs, t_hs, t_ls, t_fs, h, v, vs_e, hs_e, t_ls_e, t_fs_e);
      end
      if (t_fs === 1'b1) begin
        frames++;
        if (last >= 0) begin
          n_cmp++;
          if (cyc - last != THT * TVT) begin
            n_bad++;
            $display("FAIL frame_interval got %0d want %0d", cyc - last, THT * TVT);
          end
        end
        last = cyc;
      end
    end
    n_cmp++;
    if (frames != 3) begin
      n_bad++;
      $display("FAIL frame_count got %0d want 3", frames);
    end
  endtask

  task automatic test_enable_div4();
    int h, v, seen, want;
    seen = 0;
    want = 0;
    for (int k = 0; k < 3300; k++) begin
      tick(logic'(k % 4 == 0));
      h = d_idx % DHT;
      v = d_idx / DHT;
      if (d_ls_e) want++;
      if (d_ls === 1'b1) seen++;
      n_cmp++;
      if (d_x !== 10'(h) || d_y !== 10'(v) || d_ls !== d_ls_e) begin
        n_bad++;
        $display("FAIL enable_div4 k=%0d got x=%0d y=%0d ls=%b want %0d %0d %b",
                 k, d_x, d_y, d_ls, h, v, d_ls_e);
      end
    end
    n_cmp++;
    if (seen != want || want == 0) begin
      n_bad++;
      $display("FAIL div4_line_pulses got %0d want %0d", seen, want);
    end
  endtask

  task automatic test_polarity();
    int h, v, vs_hits;
    logic hs_e, vs_e, de_e;
    vs_hits = 0;
    repeat (60) begin
      tick(1'b1);
      h = p_idx % PHT;
      v = p_idx / PHT;
      hs_e = (h == 3);
      vs_e = (v == 3);
      de_e = (h < 2) && (v < 2);
      if (p_vs === 1'b1) vs_hits++;
      n_cmp++;
      if (p_x !== 3'(h) || p_y !== 3'(v) || p_hs !== hs_e || p_vs !== vs_e || p_de !== de_e) begin
        n_bad++;
        $display("FAIL polarity got x=%0d y=%0d hs=%b vs=%b de=%b want %0d %0d %b %b %b",
                 p_x, p_y, p_hs, p_vs, p_de, h, v, hs_e, vs_e, de_e);
      end
    end
    n_cmp++;
    if (vs_hits != 10) begin
      n_bad++;
      $display("FAIL polarity_vs_count got %0d want 10", vs_hits);
    end
  endtask

  task automatic test_small_wrap();
    int h, v;
    logic hs_e, vs_e, de_e;
    repeat (48) begin
      tick(1'b1);
      h = s_idx % SHT;
      v = s_idx / SHT;
      hs_e = !(h == 2);
      vs_e = !(v == 2);
      de_e = (h == 0) && (v == 0);
      n_cmp++;
      if (s_x !== 3'(h) || s_y !== 3'(v) || s_hs !== hs_e || s_vs !== vs_e || s_de !== de_e ||
          s_ls !== s_ls_e || s_fs !== s_fs_e) begin
        n_bad++;
        $display("FAIL small_wrap got x=%0d y=%0d hs=%b vs=%b de=%b ls=%b fs=%b want %0d %0d %b %b %b %b %b",
                 s_x, s_y, s_hs, s_vs, s_de, s_ls, s_fs, h, v, hs_e, vs_e, de_e, s_ls_e, s_fs_e);
      end
    end
  endtask

  task automatic test_midframe_reset();
    int guard, frames;
    guard = 0;
    frames = 0;
    while (!((d_idx % DHT) == 300 && (d_idx / DHT) >= 1) && guard < 2000) begin
      tick(1'b1);
      guard++;
    end
    n_cmp++;
    if (guard >= 2000 || d_x !== 10'd300) begin
      n_bad++;
      $display("FAIL midframe_reach got x=%0d guard=%0d want x=300", d_x, guard);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({d_x, d_y} !== 20'd0 || {d_de, d_ls, d_fs} !== 3'b000 || {d_hs, d_vs} !== 2'b11 ||
        {p_hs, p_vs} !== 2'b00) begin
      n_bad++;
      $display("FAIL midframe_async got x=%0d y=%0d de=%b ls=%b fs=%b hs=%b vs=%b p=%b%b want 0 0 0 0 0 1 1 00",
               d_x, d_y, d_de, d_ls, d_fs, d_hs, d_vs, p_hs, p_vs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    tick(1'b0);
    n_cmp++;
    if ({d_x, d_y} !== 20'd0 || d_de !== 1'b1 || {d_ls, d_fs} !== 2'b00) begin
      n_bad++;
      $display("FAIL midframe_restart got x=%0d y=%0d de=%b ls=%b fs=%b want 0 0 1 0 0",
               d_x, d_y, d_de, d_ls, d_fs);
    end
    repeat (900) begin
      tick(1'b1);
      if (d_fs === 1'b1) frames++;
      n_cmp++;
      if (d_x !== 10'(d_idx % DHT) || d_ls !== d_ls_e) begin
        n_bad++;
        $display("FAIL midframe_run got x=%0d ls=%b want %0d %b", d_x, d_ls, d_idx % DHT, d_ls_e);
      end
    end
    n_cmp++;
    if (frames != 0) begin
      n_bad++;
      $display("FAIL midframe_no_frame got %0d frame pulses want 0", frames);
    end
  endtask

  task automatic test_random();
    int h, v, sh, sv;
    logic e;
    repeat (2000) begin
      e = logic'($urandom_range(1, 0));
      tick(e);
      h = d_idx % DHT;
      v = d_idx / DHT;
      sh = s_idx % SHT;
      sv = s_idx / SHT;
      n_cmp++;
      if (d_x !== 10'(h) || d_y !== 10'(v) || d_de !== logic'(h < 640 && v < 480) ||
          d_hs !== logic'(!(h >= 656 && h < 752)) || d_vs !== logic'(!(v >= 490 && v < 492)) ||
          d_ls !== d_ls_e || d_fs !== d_fs_e) begin
        n_bad++;
        $display("FAIL random_d got x=%0d y=%0d de=%b hs=%b vs=%b ls=%b fs=%b want x=%0d y=%0d ls=%b fs=%b",
                 d_x, d_y, d_de, d_hs, d_vs, d_ls, d_fs, h, v, d_ls_e, d_fs_e);
      end
      n_cmp++;
      if (s_x !== 3'(sh) || s_y !== 3'(sv) || s_de !== logic'(sh == 0 && sv == 0) ||
          s_hs !== logic'(sh != 2) || s_vs !== logic'(sv != 2) ||
          s_ls !== s_ls_e || s_fs !== s_fs_e) begin
        n_bad++;
        $display("FAIL random_s got x=%0d y=%0d de=%b hs=%b vs=%b ls=%b fs=%b want x=%0d y=%0d ls=%b fs=%b",
                 s_x, s_y, s_de, s_hs, s_vs, s_ls, s_fs, sh, sv, s_ls_e, s_fs_e);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_release();
    test_line_period();
    test_vsync_tall();
    test_enable_div4();
    test_polarity();
    test_small_wrap();
    test_midframe_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
